// File: rtl/player_id_enroll.sv
// player_id_enroll: collects a 4-digit BCD player ID from the keypad and
// scans the ID table for a duplicate and a free slot. It then writes the ID
// into the synchronous ID RAM and reports the assigned slot. Slot 0 is the
// guest slot and is never assigned.
// Optional feature: define ENROLL_DELETE_EN to add del_req/del_id, which
// release an enrolled slot from IDLE.
module player_id_enroll #(
    parameter int unsigned NUM_SLOTS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  UserDigit,
    input  logic        UserLoad,
    input  logic        enroll_start,
    input  logic        logout,
`ifdef ENROLL_DELETE_EN
    input  logic        del_req,
    input  logic [2:0]  del_id,
`endif
    output logic [4:0]  addr,
    input  logic [15:0] rd_data,
    output logic [15:0] wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        enrolled,
    output logic [2:0]  assigned_id,
    output logic        dup_error,
    output logic        full_error,
    output logic        timeout_error
);

    localparam int unsigned TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_SLOT  = 3'(NUM_SLOTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SCAN_ADDR,
        SCAN_CMP,
        WRITE
    } state_t;

    state_t               state;
    logic [NUM_SLOTS-1:0] valid;
    logic [1:0]           digit_cnt;
    logic [15:0]          sr;
    logic [TW-1:0]        timer;
    logic [2:0]           slot;
    logic [2:0]           free_slot;
    logic                 free_found;

    logic                 digit_ok;
    logic                 slot_free;
    logic                 cand_found;
    logic [2:0]           cand_slot;

    // Decode the keypad strobe and the free-slot candidate seen at the current scan position.
    always_comb begin
        digit_ok   = UserLoad && (UserDigit <= 4'd9);
        slot_free  = !valid[slot];
        cand_found = free_found || slot_free;
        cand_slot  = free_found ? free_slot : slot;
    end

    // Enrollment FSM with registered RAM port and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            valid         <= '0;
            digit_cnt     <= '0;
            sr            <= '0;
            timer         <= '0;
            slot          <= '0;
            free_slot     <= '0;
            free_found    <= 1'b0;
            addr          <= '0;
            wr_data       <= '0;
            wr_en         <= 1'b0;
            busy          <= 1'b0;
            enrolled      <= 1'b0;
            assigned_id   <= '0;
            dup_error     <= 1'b0;
            full_error    <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            wr_en         <= 1'b0;
            enrolled      <= 1'b0;
            dup_error     <= 1'b0;
            full_error    <= 1'b0;
            timeout_error <= 1'b0;

            // A write already on the RAM port is allowed to finish; logout
            // takes effect from the cycle after it.
            if (logout && (state != IDLE) && (state != WRITE)) begin
                state <= IDLE;
                busy  <= 1'b0;
                addr  <= '0;
            end else begin
                case (state)
                    IDLE: begin
`ifdef ENROLL_DELETE_EN
                        if (del_req && (del_id != 3'd0) && (del_id <= LAST_SLOT))
                            valid[del_id] <= 1'b0;
`endif
                        if (enroll_start) begin
                            state     <= COLLECT;
                            busy      <= 1'b1;
                            digit_cnt <= '0;
                            sr        <= '0;
                            timer     <= '0;
                        end
                    end

                    COLLECT: begin
                        if (digit_ok) begin
                            sr        <= {sr[11:0], UserDigit};
                            digit_cnt <= digit_cnt + 1'b1;
                            timer     <= '0;
                            if (digit_cnt == 2'd3) begin
                                state      <= SCAN_ADDR;
                                slot       <= 3'd1;
                                addr       <= 5'd1;
                                free_found <= 1'b0;
                                free_slot  <= '0;
                            end
                        end else if (timer == TIMER_LAST) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            timeout_error <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end

                    // Both scan states share the advance logic. An empty slot
                    // skips the RAM read. The last slot hands the candidate
                    // straight to the write port, so the free slot can be
                    // found on the final step.
                    SCAN_ADDR, SCAN_CMP: begin
                        if ((state == SCAN_CMP) && (rd_data == sr)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            addr      <= '0;
                            dup_error <= 1'b1;
                        end else if ((state == SCAN_ADDR) && !slot_free) begin
                            state <= SCAN_CMP;
                        end else begin
                            if (slot_free && !free_found) begin
                                free_found <= 1'b1;
                                free_slot  <= slot;
                            end
                            if (slot != LAST_SLOT) begin
                                slot  <= slot + 3'd1;
                                addr  <= {2'b00, slot + 3'd1};
                                state <= SCAN_ADDR;
                            end else if (cand_found) begin
                                state   <= WRITE;
                                addr    <= {2'b00, cand_slot};
                                wr_data <= sr;
                                wr_en   <= 1'b1;
                            end else begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                addr       <= '0;
                                full_error <= 1'b1;
                            end
                        end
                    end

                    WRITE: begin
                        valid[free_slot] <= 1'b1;
                        assigned_id      <= free_slot;
                        enrolled         <= 1'b1;
                        wr_data          <= '0;
                        addr             <= '0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        addr  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/player_id_enroll.md
Name: player_id_enroll

Overview:
- Writer-side counterpart to the player-ID authentication path.
- Collects a new 4-digit player ID from the keypad and scans the ID table for duplicates and a free slot.
- Writes the ID into the synchronous ID RAM that the authentication path reads, and reports the assigned player number.
- Sits between the keypad/debouncer and the ID RAM write port.

Parameters:
- NUM_SLOTS, 8, number of ID table slots; slot 0 is reserved for guest and never assigned.
- TIMEOUT_CYCLES, 50000000, idle cycles allowed between digits before entry is abandoned.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- UserDigit  input  4  BCD digit from keypad
- UserLoad  input  1  single-cycle strobe; UserDigit valid this cycle
- enroll_start  input  1  single-cycle strobe; begin enrollment
- logout  input  1  abort any enrollment in progress
- addr  output  5  ID RAM address; slot index zero-extended
- rd_data  input  16  ID RAM read data; one-cycle latency after addr
- wr_data  output  16  ID RAM write data
- wr_en  output  1  ID RAM write strobe
- busy  output  1  high in any state other than IDLE
- enrolled  output  1  one-cycle pulse when the write completes
- assigned_id  output  3  slot written; held until the next enrollment
- dup_error  output  1  one-cycle pulse; ID already present
- full_error  output  1  one-cycle pulse; no free slot
- timeout_error  output  1  one-cycle pulse; digit entry timed out

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0.
  - Internal valid[NUM_SLOTS-1:0]=0, digit count=0, shift register=0.
- IDLE:
  - enroll_start -> COLLECT; clear digit count, shift register and timer.
  - UserLoad in IDLE is ignored.
- COLLECT:
  - On UserLoad with UserDigit<=9: shift register={sr[11:0],UserDigit}, count++, timer cleared. First digit ends in [15:12].
  - UserDigit>9 is ignored: no count change, timer not cleared.
  - When the 4th digit is accepted -> SCAN_ADDR with slot=1.
  - Timer reaching TIMEOUT_CYCLES-1 -> IDLE; pulse timeout_error.
- SCAN_ADDR:
  - Drive addr=slot.
  - If valid[slot]=0: record it as the free slot if none is recorded yet; skip the read and advance.
  - Otherwise -> SCAN_CMP.
- SCAN_CMP:
  - rd_data is the data for addr issued the previous cycle.
  - Match with the shift register -> IDLE; pulse dup_error.
  - Otherwise advance.
- Advance:
  - slot<NUM_SLOTS-1 -> slot++, SCAN_ADDR.
  - Else -> WRITE if a free slot is recorded; otherwise IDLE and pulse full_error.
  - Full scan cost: at most 2*(NUM_SLOTS-1) cycles.
- WRITE (1 cycle):
  - addr=free slot, wr_data=shift register, wr_en=1.
  - Next cycle: valid[slot]=1, assigned_id=slot, enrolled pulse, -> IDLE.
- Output timing:
  - wr_en is high for exactly one cycle.
  - addr is 0 outside SCAN and WRITE.
- logout:
  - In any non-IDLE state -> IDLE next cycle, no error pulse, no write.
  - If asserted in the WRITE cycle itself, the write still completes; logout wins from the following cycle.
- Simultaneous events:
  - enroll_start while busy is ignored.
  - UserLoad on the same cycle as the timeout: the digit wins and the timer clears.
- Reset mid-operation: abandons enrollment and clears valid[]. Table contents in RAM persist but are treated as empty.

Optional Feature:
- Macro ENROLL_DELETE_EN.
- When defined, adds two ports:
  - del_req  input  1  single-cycle strobe
  - del_id  input  3  slot to delete
- del_req in IDLE with del_id in 1..NUM_SLOTS-1 clears valid[del_id] next cycle; RAM is not written.
- del_req is ignored when busy or when del_id=0.
- When undefined, the ports are absent and slots are only freed by reset.

Test Plan:
- Enroll 1,2,3,4 into an empty table -> one wr_en at addr=1 with wr_data=16'h1234; next cycle enrolled=1, assigned_id=1; busy drops.
- Enroll 1234, then 5678 -> second write at addr=2; the scan reads slot 1 (rd_data=16'h1234), no match.
- Enroll 1234 twice -> second attempt pulses dup_error after the SCAN_CMP of slot 1; no wr_en.
- Fill slots 1-7, then enroll 9999 -> full_error after 14 scan cycles; no wr_en.
- Enter 1,2 then stop with TIMEOUT_CYCLES=16 -> timeout_error 16 cycles after the digit 2 strobe.
- Digit sequence 1,A,2,3,4 -> A ignored, write 16'h1234.
- logout after 3 digits -> IDLE with no pulses.
- rst low mid-scan -> all outputs 0 immediately.
